// File: rtl/whack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : whack_pkg
// Description : Shared definitions for the whack-a-mole round sequencer:
//               FSM state encoding, LFSR seed/tap mask, datapath widths and
//               the LFSR next-state helper.
// Revision    : 1.0 - initial release
// ============================================================================
package whack_pkg;

    // Datapath widths shared with the display / timer blocks
    localparam int SCORE_W    = 4;
    localparam int INTERVAL_W = 3;
    localparam int ROUND_W    = 4;

    // 8-bit Fibonacci LFSR, x^8 + x^6 + x^5 + x^4 + 1.
    // With a left shift, those polynomial terms land on bits 7, 5, 4 and 3.
    localparam logic [7:0] c_LFSR_SEED = 8'hA5;
    localparam logic [7:0] c_LFSR_TAPS = 8'b1011_1000;

    // Round sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_JUDGE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Plain-vector aliases of the state encoding, used by the FSM registers
    localparam logic [2:0] c_ST_IDLE  = ST_IDLE;
    localparam logic [2:0] c_ST_ARM   = ST_ARM;
    localparam logic [2:0] c_ST_WAIT  = ST_WAIT;
    localparam logic [2:0] c_ST_JUDGE = ST_JUDGE;
    localparam logic [2:0] c_ST_DONE  = ST_DONE;

    // One LFSR step: shift left and feed the tap parity into bit 0
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & c_LFSR_TAPS)};
    endfunction

endpackage : whack_pkg
`default_nettype wire

// File: rtl/whack_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : whack_lfsr
// Description : Free-running 8-bit Fibonacci LFSR. Steps every clock and is
//               reloaded with the seed by a synchronous active-high reset.
//               Only the low OUT_W bits are exported.
// Ports       : clk   - clock
//               rst   - synchronous active-high reset (reloads the seed)
//               o_rnd - low OUT_W bits of the current LFSR state
// Revision    : 1.0 - initial release
// ============================================================================
module whack_lfsr
    import whack_pkg::*;
#(
    parameter int OUT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic [OUT_W-1:0] o_rnd
);

    logic [7:0] r_lfsr;

    // A nonzero seed on this polynomial never reaches the all-zero lockup
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= c_LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign o_rnd = r_lfsr[OUT_W-1:0];

endmodule : whack_lfsr
`default_nettype wire

// File: rtl/whack_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : whack_round_ctrl
// Description : Round sequencer for the whack-a-mole game. Reloads the
//               interval timer, picks a pseudo-random mole per round, judges
//               button presses as hit/miss, and tracks score and rounds.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               start         - one-cycle game start pulse (IDLE/DONE only)
//               btn           - debounced one-cycle press pulses, one per mole
//               timeout       - one-cycle terminal-count pulse from the timer
//               timer_reset   - one-cycle timer reload pulse (ARM cycle)
//               interval      - seconds for the current round
//               dir           - timer direction, always 0 (count down)
//               mole          - one-hot active mole, zero when none is up
//               score, round  - hits / completed rounds in this game
//               hit, miss     - one-cycle verdict pulses
//               game_over     - high while the game is finished
// Options     : WHACK_SPEEDUP_EN - when defined, every hit shortens the
//               interval by one second, floored at MIN_INTERVAL.
// Revision    : 1.0 - initial release
// ============================================================================
module whack_round_ctrl
    import whack_pkg::*;
#(
    parameter int NUM_MOLES      = 4,
    parameter int NUM_ROUNDS     = 8,
    parameter int START_INTERVAL = 5,
    parameter int MIN_INTERVAL   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NUM_MOLES-1:0]  btn,
    input  logic                  timeout,
    output logic                  timer_reset,
    output logic [INTERVAL_W-1:0] interval,
    output logic                  dir,
    output logic [NUM_MOLES-1:0]  mole,
    output logic [SCORE_W-1:0]    score,
    output logic [ROUND_W-1:0]    round,
    output logic                  hit,
    output logic                  miss,
    output logic                  game_over
);

    localparam int c_IDX_W = (NUM_MOLES > 1) ? $clog2(NUM_MOLES) : 1;

    // The game never starts below the floor, even if misconfigured
    localparam logic [INTERVAL_W-1:0] c_START =
        (START_INTERVAL < MIN_INTERVAL) ? INTERVAL_W'(MIN_INTERVAL)
                                        : INTERVAL_W'(START_INTERVAL);
`ifdef WHACK_SPEEDUP_EN
    localparam logic [INTERVAL_W-1:0] c_FLOOR = INTERVAL_W'(MIN_INTERVAL);
`endif
    localparam logic [ROUND_W-1:0] c_LAST_ROUND = ROUND_W'(NUM_ROUNDS);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]            r_state;
    logic                  r_timer_reset;
    logic [INTERVAL_W-1:0] r_interval;
    logic [NUM_MOLES-1:0]  r_mole;
    logic [SCORE_W-1:0]    r_score;
    logic [ROUND_W-1:0]    r_round;
    logic                  r_hit;
    logic                  r_miss;
    logic                  r_game_over;
    logic [c_IDX_W-1:0]    r_prev_idx;
    logic                  r_prev_valid;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [c_IDX_W-1:0]    w_rnd;
    logic [c_IDX_W-1:0]    w_pick_avoid;
    logic [c_IDX_W-1:0]    w_sel_idx;
    logic [NUM_MOLES-1:0]  w_sel_onehot;
    logic                  w_hit;
    logic                  w_miss;
    logic [SCORE_W-1:0]    w_score_inc;
    logic [INTERVAL_W-1:0] w_interval_hit;

    whack_lfsr #(
        .OUT_W (c_IDX_W)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .o_rnd (w_rnd)
    );

    // Never repeat the previous round's mole; NUM_MOLES is a power of two,
    // so the +1 wraps modulo NUM_MOLES by itself.
    assign w_pick_avoid = (r_prev_valid && (w_rnd == r_prev_idx))
                        ? w_rnd + c_IDX_W'(1) : w_rnd;

    // First round of a game has no previous mole to avoid
    assign w_sel_idx = (r_state == c_ST_JUDGE) ? w_pick_avoid : w_rnd;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MOLES; gi++) begin : g_onehot
            assign w_sel_onehot[gi] = (w_sel_idx == c_IDX_W'(gi));
        end
    endgenerate

    // A correct press wins over any wrong press or a coincident timeout
    assign w_hit  = |(btn & r_mole);
    assign w_miss = ~w_hit & ((|btn) | timeout);

    assign w_score_inc = (r_score == {SCORE_W{1'b1}}) ? r_score
                                                      : r_score + SCORE_W'(1);

`ifdef WHACK_SPEEDUP_EN
    assign w_interval_hit = (r_interval > c_FLOOR) ? r_interval - INTERVAL_W'(1)
                                                   : c_FLOOR;
`else
    assign w_interval_hit = r_interval;
`endif

    // ------------------------------------------------------------------
    // Round FSM and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_timer_reset <= 1'b0;
            r_interval    <= c_START;
            r_mole        <= '0;
            r_score       <= '0;
            r_round       <= '0;
            r_hit         <= 1'b0;
            r_miss        <= 1'b0;
            r_game_over   <= 1'b0;
            r_prev_idx    <= '0;
            r_prev_valid  <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle
            r_timer_reset <= 1'b0;
            r_hit         <= 1'b0;
            r_miss        <= 1'b0;

            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (start) begin
                        r_state       <= c_ST_ARM;
                        r_score       <= '0;
                        r_round       <= '0;
                        r_interval    <= c_START;
                        r_game_over   <= 1'b0;
                        r_timer_reset <= 1'b1;
                        r_mole        <= w_sel_onehot;
                        r_prev_idx    <= w_sel_idx;
                        r_prev_valid  <= 1'b1;
                    end
                end

                c_ST_ARM: begin
                    r_state <= c_ST_WAIT;
                end

                c_ST_WAIT: begin
                    // Verdict, counters and interval all land together so
                    // they are coherent during the JUDGE cycle.
                    if (w_hit || w_miss) begin
                        r_state <= c_ST_JUDGE;
                        r_mole  <= '0;
                        r_hit   <= w_hit;
                        r_miss  <= w_miss;
                        r_round <= r_round + ROUND_W'(1);
                        if (w_hit) begin
                            r_score    <= w_score_inc;
                            r_interval <= w_interval_hit;
                        end
                    end
                end

                c_ST_JUDGE: begin
                    if (r_round == c_LAST_ROUND) begin
                        r_state     <= c_ST_DONE;
                        r_game_over <= 1'b1;
                    end else begin
                        r_state       <= c_ST_ARM;
                        r_timer_reset <= 1'b1;
                        r_mole        <= w_sel_onehot;
                        r_prev_idx    <= w_sel_idx;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign timer_reset = r_timer_reset;
    assign interval    = r_interval;
    assign dir         = 1'b0;
    assign mole        = r_mole;
    assign score       = r_score;
    assign round       = r_round;
    assign hit         = r_hit;
    assign miss        = r_miss;
    assign game_over   = r_game_over;

endmodule : whack_round_ctrl
`default_nettype wire

// File: tb/tb_whack_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_whack_round_ctrl
// Description : Self-checking bench for whack_round_ctrl. A driver plays
//               games with randomized actions and pushes expected ARM,
//               verdict and game-over records into queues; a negedge monitor
//               pops and compares whenever the DUT presents one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_whack_round_ctrl;

    localparam int NM = 4;
    localparam int NR = 8;
    localparam int SI = 5;
    localparam int MI = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NM-1:0] btn;
    logic          timeout;
    logic          timer_reset;
    logic [2:0]    interval;
    logic          dir;
    logic [NM-1:0] mole;
    logic [3:0]    score;
    logic [3:0]    round;
    logic          hit;
    logic          miss;
    logic          game_over;

    whack_round_ctrl #(
        .NUM_MOLES      (NM),
        .NUM_ROUNDS     (NR),
        .START_INTERVAL (SI),
        .MIN_INTERVAL   (MI)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .btn         (btn),
        .timeout     (timeout),
        .timer_reset (timer_reset),
        .interval    (interval),
        .dir         (dir),
        .mole        (mole),
        .score       (score),
        .round       (round),
        .hit         (hit),
        .miss        (miss),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard records
    // ------------------------------------------------------------------
    typedef struct {
        logic [NM-1:0] mole;
        logic [2:0]    interval;
    } arm_t;

    typedef struct {
        logic       hit;
        logic       miss;
        logic [3:0] score;
        logic [3:0] round;
    } verd_t;

    typedef struct {
        logic [3:0] score;
        logic [3:0] round;
    } done_t;

    arm_t  arm_q[$];
    verd_t verd_q[$];
    done_t done_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s (t=%0t)", name, what, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: game rules in plain arithmetic
    // ------------------------------------------------------------------
    // Random source: x^8+x^6+x^5+x^4+1 Fibonacci, seed A5, one step per clock
    logic [7:0] m_lfsr;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    always @(posedge clk) m_lfsr <= rst ? 8'hA5 : lfsr_step(m_lfsr);

    int            m_prev;      // previous round's mole index, -1 if none
    int            m_score;
    int            m_round;
    int            m_interval;
    logic [NM-1:0] m_mole;

    // Expected ARM for a selection made from LFSR value lv
    task automatic push_arm(input logic [7:0] lv);
        arm_t a;
        int   idx;
        idx = int'(lv) % NM;
        if (idx == m_prev) idx = (idx + 1) % NM;
        m_prev     = idx;
        m_mole     = NM'(1 << idx);
        a.mole     = m_mole;
        a.interval = 3'(m_interval);
        arm_q.push_back(a);
    endtask

    function automatic logic [NM-1:0] wrong_btns();
        logic [NM-1:0] w;
        w = NM'($urandom_range(1, (1 << NM) - 1)) & ~m_mole;
        if (w == '0) w = ~m_mole;
        return w;
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_timer_reset"}, 32'(timer_reset), 0);
        check({tag, "_mole"},        32'(mole),        0);
        check({tag, "_score"},       32'(score),       0);
        check({tag, "_round"},       32'(round),       0);
        check({tag, "_hit"},         32'(hit),         0);
        check({tag, "_miss"},        32'(miss),        0);
        check({tag, "_game_over"},   32'(game_over),   0);
        check({tag, "_dir"},         32'(dir),         0);
        check({tag, "_interval"},    32'(interval),    SI);
    endtask

    // Sync helper: called at a negedge, returns at the negedge of the ARM cycle
    task automatic wait_arm();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 6 && !ok; i++) begin
            if (timer_reset === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) fail_now("arm_wait", "timer_reset not seen within 6 cycles");
    endtask

    // Called at a negedge in IDLE/DONE
    task automatic do_start();
        start      = 1'b1;
        m_prev     = -1;
        m_score    = 0;
        m_round    = 0;
        m_interval = SI;
        push_arm(m_lfsr);
        @(negedge clk);
        start = 1'b0;
        wait_arm();
    endtask

    // Called at the negedge of the ARM cycle.
    // act: 0 correct, 1 wrong, 2 timeout, 3 correct+timeout,
    //      4 correct+wrong, 5 wrong+timeout
    task automatic play_round(input int act, input int d, input bit noise);
        logic [NM-1:0] b;
        logic          t;
        bit            h;
        verd_t         v;
        done_t         dn;
        @(posedge clk);                 // into WAIT
        repeat (d) @(posedge clk);      // mole sits up with no input
        @(negedge clk);
        case (act)
            0:       begin b = m_mole;                t = 1'b0; end
            1:       begin b = wrong_btns();          t = 1'b0; end
            2:       begin b = '0;                    t = 1'b1; end
            3:       begin b = m_mole;                t = 1'b1; end
            4:       begin b = m_mole | wrong_btns(); t = 1'b0; end
            default: begin b = wrong_btns();          t = 1'b1; end
        endcase
        btn     = b;
        timeout = t;

        h = ((b & m_mole) != '0);
        m_round++;
        if (h && m_score < 15) m_score++;
`ifdef WHACK_SPEEDUP_EN
        if (h && m_interval > MI) m_interval--;
`endif
        v.hit   = h;
        v.miss  = !h;
        v.score = 4'(m_score);
        v.round = 4'(m_round);
        verd_q.push_back(v);
        if (m_round == NR) begin
            dn.score = 4'(m_score);
            dn.round = 4'(m_round);
            done_q.push_back(dn);
        end else begin
            // next mole is drawn one clock after the verdict edge
            push_arm(lfsr_step(m_lfsr));
        end

        @(posedge clk);                 // verdict edge
        @(negedge clk);                 // JUDGE cycle: inputs here are ignored
        if (noise) begin
            btn     = NM'($urandom);
            timeout = 1'($urandom);
        end else begin
            btn     = '0;
            timeout = 1'b0;
        end
        @(negedge clk);
        btn     = '0;
        timeout = 1'b0;
        if (m_round != NR) wait_arm();
    endtask

    // Called at the negedge of the ARM cycle: reset lands mid-WAIT with a
    // correct press pending, which must not produce a verdict.
    task automatic rst_in_wait();
        @(posedge clk);
        @(negedge clk);
        rst     = 1'b1;
        btn     = m_mole;
        timeout = 1'b1;
        @(negedge clk);
        check_reset("mid_rst");
        rst     = 1'b0;
        btn     = '0;
        timeout = 1'b0;
        m_prev  = -1;
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    bit prev_tr = 1'b0;
    bit prev_go = 1'b0;

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (hit === 1'b1 || miss === 1'b1) begin
                if (verd_q.size() == 0) begin
                    fail_now("verdict", $sformatf("unexpected hit=%0b miss=%0b", hit, miss));
                end else begin
                    verd_t v;
                    v = verd_q.pop_front();
                    check("verdict_hit",   32'(hit),   32'(v.hit));
                    check("verdict_miss",  32'(miss),  32'(v.miss));
                    check("verdict_score", 32'(score), 32'(v.score));
                    check("verdict_round", 32'(round), 32'(v.round));
                    check("verdict_mole_clear", 32'(mole), 0);
                end
            end
            if (timer_reset === 1'b1) begin
                if (prev_tr) fail_now("timer_reset_width", "pulse longer than one cycle");
                if (arm_q.size() == 0) begin
                    fail_now("arm", "unexpected timer_reset");
                end else begin
                    arm_t a;
                    a = arm_q.pop_front();
                    check("arm_mole",     32'(mole),     32'(a.mole));
                    check("arm_interval", 32'(interval), 32'(a.interval));
                    check("arm_dir",      32'(dir),      0);
                end
            end
            if (game_over === 1'b1 && !prev_go) begin
                if (done_q.size() == 0) begin
                    fail_now("game_over", "unexpected rise");
                end else begin
                    done_t dn;
                    dn = done_q.pop_front();
                    check("done_score", 32'(score), 32'(dn.score));
                    check("done_round", 32'(round), 32'(dn.round));
                end
            end
            prev_tr = (timer_reset === 1'b1);
            prev_go = (game_over === 1'b1);
        end else begin
            prev_tr = 1'b0;
            prev_go = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        btn     = '0;
        timeout = 1'b0;
        m_prev  = -1;
        m_score = 0;
        m_round = 0;
        m_interval = SI;
        m_mole  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);

        // Game 1: directed verdict cases, then random rounds
        do_start();
        play_round(0, 1, 1'b0);     // correct press two cycles after ARM
        play_round(1, 0, 1'b0);     // wrong press
        play_round(2, 2, 1'b0);     // timeout only
        play_round(3, 0, 1'b1);     // correct press with timeout
        play_round(4, 1, 1'b0);     // correct with wrong press
        for (int r = 5; r < NR; r++)
            play_round($urandom_range(0, 5), $urandom_range(0, 3), 1'($urandom));

        // DONE ignores buttons and timeout
        btn     = '1;
        timeout = 1'b1;
        repeat (2) @(negedge clk);
        btn     = '0;
        timeout = 1'b0;
        check("done_hold_game_over", 32'(game_over), 1);
        check("done_hold_round",     32'(round),     NR);
        repeat ($urandom_range(0, 2)) @(negedge clk);

        // Game 2: restart from DONE, every round a hit
        do_start();
        for (int r = 0; r < NR; r++) begin
            int a;
            a = $urandom_range(0, 2);
            play_round((a == 0) ? 0 : (a == 1) ? 3 : 4, $urandom_range(0, 3), 1'($urandom));
        end
        @(negedge clk);
        check("all_hit_score", 32'(score), NR);
`ifdef WHACK_SPEEDUP_EN
        check("all_hit_interval", 32'(interval), MI);
`else
        check("all_hit_interval", 32'(interval), SI);
`endif

        // Game 3: reset lands in the middle of a round
        do_start();
        for (int r = 0; r < 2; r++)
            play_round($urandom_range(0, 5), $urandom_range(0, 2), 1'($urandom));
        rst_in_wait();
        repeat (2) @(negedge clk);
        check("post_rst_idle_mole", 32'(mole), 0);

        // Game 4: fully random game from IDLE
        do_start();
        for (int r = 0; r < NR; r++)
            play_round($urandom_range(0, 5), $urandom_range(0, 3), 1'($urandom));
        repeat (3) @(negedge clk);

        check("arm_q_drained",  32'(arm_q.size()),  0);
        check("verd_q_drained", 32'(verd_q.size()), 0);
        check("done_q_drained", 32'(done_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_whack_round_ctrl
`default_nettype wire
